// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and default width.
package seq_divider_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_ripple_subtractor.sv
// N-bit a - b as a ripple chain of full-adder cells (a + ~b + 1); carry_out=1 means no borrow.
module ripple_subtractor #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         carry_out
);

  logic [N:0]   carry;
  logic [N-1:0] b_n;

  assign carry[0] = 1'b1;
  assign b_n      = ~b;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign diff[i]      = a[i] ^ b_n[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b_n[i]) | (carry[i] & (a[i] ^ b_n[i]));
  end

  assign carry_out = carry[N];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned PW    = WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [PW-1:0]      p_q, p_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dz_q, dz_d;
  logic               busy_d, done_d, dbz_d;
  logic [WIDTH-1:0]   quo_d, rem_d;

  logic [PW-1:0]      p_shift_c;
  logic [WIDTH-1:0]   q_shift_c;
  logic [PW-1:0]      trial_c;
  logic               no_borrow_c;
  logic               accept_c;

  // Shift {P,Q} left by one; trial subtraction runs on the shifted partial remainder
  assign p_shift_c = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign q_shift_c = {q_q[WIDTH-2:0], 1'b0};

  ripple_subtractor #(.N(PW)) u_sub (
    .a         (p_shift_c),
    .b         ({1'b0, dvs_q}),
    .diff      (trial_c),
    .carry_out (no_borrow_c)
  );

  assign accept_c = start && (state_q != ST_RUN);

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    quo_d   = quotient;
    rem_d   = remainder;
    dbz_d   = div_by_zero;

    case (state_q)
      ST_RUN: begin
        if (no_borrow_c) begin
          p_d = trial_c;
          q_d = q_shift_c | WIDTH'(1);
        end else begin
          p_d = p_shift_c;
          q_d = q_shift_c;
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        quo_d   = q_q;
        rem_d   = p_q[WIDTH-1:0];
        dbz_d   = dz_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // New request from IDLE or straight out of DONE (back-to-back)
    if (accept_c) begin
      dvs_d = divisor;
      if (divisor == '0) begin
        state_d = ST_DONE;
        p_d     = {1'b0, dividend};
        q_d     = '1;
        cnt_d   = '0;
        dz_d    = 1'b1;
      end else begin
        state_d = ST_RUN;
        p_d     = '0;
        q_d     = dividend;
        cnt_d   = CNT_W'(WIDTH);
        dz_d    = 1'b0;
      end
    end

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      p_q         <= '0;
      q_q         <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      dz_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      q_q         <= q_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      dz_q        <= dz_d;
      busy        <= busy_d;
      done        <= done_d;
      quotient    <= quo_d;
      remainder   <= rem_d;
      div_by_zero <= dbz_d;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=8): directed handshake cases plus boundary/random operand sweep.
module tb_seq_divider;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference result for one request
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.quo = '1;
      e.rem = a;
      e.dz  = 1'b1;
    end else begin
      e.quo = a / b;
      e.rem = a % b;
      e.dz  = 1'b0;
    end
    return e;
  endfunction

  // Pop and compare whenever the DUT reports a result
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.quo);
        chk("remainder", remainder, e.rem);
        chk("div_by_zero", div_by_zero, e.dz);
      end
    end
  end

  // Caller is at a negedge; drives a request and records its expectation
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(model(a, b));
  endtask

  // Issue, then report edges-to-done latency and number of busy cycles
  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int bcnt);
    issue(a, b);
    lat  = 0;
    bcnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        lat = k - 1;
        break;
      end
    end
    if (lat == 0) chk("done_timeout", done, 1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) return;
    end
    chk("done_timeout", done, 1);
  endtask

  initial begin
    int lat, bcnt, d0;
    logic [W-1:0] edge_vals [6];

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 100/7 with latency and busy-length checks
    run_one(8'd100, 8'd7, lat, bcnt);
    chk("lat_100_7", lat, W + 1);
    chk("busy_cycles_100_7", bcnt, W);
    @(negedge clk);
    chk("done_single_pulse", done, 0);

    // Back-to-back: second request issued in the DONE cycle
    issue(8'd255, 8'd1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (!busy) break;
    end
    chk("b2b_in_done_state", done, 0);
    issue(8'd5, 8'd9);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy_overlap", busy, 1);
    chk("b2b_done_overlap", done, 1);
    wait_done();

    // Divide by zero, then a normal divide clears the flag
    run_one(8'd200, 8'd0, lat, bcnt);
    chk("lat_div0", lat, 1);
    chk("busy_cycles_div0", bcnt, 0);
    @(negedge clk);
    run_one(8'd200, 8'd10, lat, bcnt);
    @(negedge clk);

    // Start with new operands during RUN is ignored
    d0 = done_cnt;
    issue(8'd100, 8'd7);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 8'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (15) @(negedge clk);
    chk("ignored_start_one_done", done_cnt - d0, 1);

    // Asynchronous reset between clock edges mid-RUN
    issue(8'd100, 8'd7);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_quotient", quotient, 0);
    chk("async_rst_remainder", remainder, 0);
    chk("async_rst_dbz", div_by_zero, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_one(8'd0, 8'd3, lat, bcnt);
    @(negedge clk);

    // Boundary operand grid
    edge_vals = '{8'd0, 8'd1, 8'd127, 8'd128, 8'd254, 8'd255};
    foreach (edge_vals[i]) begin
      foreach (edge_vals[j]) begin
        run_one(edge_vals[i], edge_vals[j], lat, bcnt);
        @(negedge clk);
      end
    end

    // Random nonzero-divisor sweep
    for (int n = 0; n < 1500; n++) begin
      run_one(W'($urandom_range(255, 0)), W'($urandom_range(255, 1)), lat, bcnt);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
